phased_array_ctrl: RTL and testbench

//  Byte-stream-controlled N-channel phased square-wave generator for the transducer array.

---
 rtl/pac_pkg.sv | 29 ++
 rtl/phased_array_ctrl_if.sv | 19 +
 rtl/phase_channel.sv | 46 ++++
 rtl/phased_array_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_phased_array_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pac_pkg.sv
// Shared definitions for the phased-array controller: opcodes, reply codes,
// frame bit positions, parser state encoding and frame field extraction.
package pac_pkg;

  localparam logic [1:0] OP_SET_OFFSET = 2'b00;
  localparam logic [1:0] OP_COMMIT     = 2'b01;
  localparam logic [1:0] OP_QUERY      = 2'b10;
  localparam logic [1:0] OP_SET_DUTY   = 2'b11;

  localparam logic [7:0] REPLY_ERR = 8'hEE;

  // Bit 7 marks the first byte of a frame; the opcode sits just below it.
  localparam int unsigned FRAME_MARK_BIT = 7;
  localparam int unsigned OP_MSB         = 6;
  localparam int unsigned OP_LSB         = 5;
  localparam int unsigned V_WIDTH        = 12;

  typedef enum logic [1:0] {IDLE, GOT1, GOT2, EXEC} parse_state_t;

  // Payload bytes are stored without their marker bit.
  function automatic logic [6:0] frame_ch(logic [6:0] b0, logic [6:0] b1);
    return {b0[4:0], b1[6:5]};
  endfunction

  function automatic logic [V_WIDTH-1:0] frame_v(logic [6:0] b1, logic [6:0] b2);
    return {b1[4:0], b2};
  endfunction

endpackage

// File: rtl/phased_array_ctrl_if.sv
// Byte-stream bus between the UART and the phased-array controller.
interface phased_array_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/phase_channel.sv
// One transducer channel: active offset/duty registers and the phase comparator
// that produces the registered drive bit.
module phase_channel #(
  parameter int unsigned OFFSET_WIDTH = 12,
  parameter int unsigned PERIOD       = 1250
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OFFSET_WIDTH-1:0] cnt,
  input  logic                    swap,
  input  logic [OFFSET_WIDTH-1:0] shadow_off,
  input  logic [OFFSET_WIDTH-1:0] shadow_duty,
  output logic                    out
);

  localparam logic [OFFSET_WIDTH-1:0] DUTY_RESET = OFFSET_WIDTH'(PERIOD / 2);
  localparam logic [OFFSET_WIDTH:0]   PERIOD_X   = (OFFSET_WIDTH + 1)'(PERIOD);

  logic [OFFSET_WIDTH-1:0] off_q, duty_q;
  logic [OFFSET_WIDTH:0]   diff;

  // Phase of the counter relative to this channel's offset, modulo PERIOD.
  always_comb begin
    if (cnt >= off_q) begin
      diff = {1'b0, cnt} - {1'b0, off_q};
    end else begin
      diff = {1'b0, cnt} + PERIOD_X - {1'b0, off_q};
    end
  end

  // Active set reloads from shadow only on the swap strobe; output is registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      off_q  <= '0;
      duty_q <= DUTY_RESET;
      out    <= 1'b0;
    end else begin
      if (swap) begin
        off_q  <= shadow_off;
        duty_q <= shadow_duty;
      end
      out <= (diff < {1'b0, duty_q});
    end
  end

endmodule

// File: rtl/phased_array_ctrl.sv
// Byte-stream-controlled N-channel phased square-wave generator.
// Holds the period counter, 3-byte frame parser, shadow registers and reply logic.
// Define PAC_ACK_EN to echo B0 on every valid SET/COMMIT frame.
module phased_array_ctrl
  import pac_pkg::*;
#(
  parameter int unsigned OUTPUTS      = 88,
  parameter int unsigned OFFSET_WIDTH = 12,
  parameter int unsigned PERIOD       = 1250,
  parameter int unsigned CH_WIDTH     = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  phased_array_ctrl_if.slave   bus,
  output logic [OUTPUTS-1:0]   out,
  output logic                 sync,
  output logic                 commit_pending
);

  localparam logic [OFFSET_WIDTH-1:0] LAST        = OFFSET_WIDTH'(PERIOD - 1);
  localparam logic [OFFSET_WIDTH-1:0] DUTY_RESET  = OFFSET_WIDTH'(PERIOD / 2);
  localparam logic [7:0]              QUERY_REPLY = 8'(OUTPUTS);
`ifdef PAC_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;
  logic                    swap;
  parse_state_t            state_q, state_d;
  logic [6:0]              b0_q, b1_q, b2_q;
  logic                    accept, mark, is_exec, live_q;
  logic [1:0]              op;
  logic [CH_WIDTH-1:0]     ch;
  logic [V_WIDTH-1:0]      v;
  logic                    ch_ok, v_ok, wr_off, wr_duty, commit_req;
  logic                    reply_valid;
  logic [7:0]              reply_data;
  logic                    tx_valid_q;
  logic [7:0]              tx_data_q;
  logic [OFFSET_WIDTH-1:0] shadow_off  [OUTPUTS];
  logic [OFFSET_WIDTH-1:0] shadow_duty [OUTPUTS];

  assign cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  assign swap  = (cnt_q == LAST) && commit_pending;

  // Period counter and sync pulse aligned with cnt == 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      sync  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sync  <= (cnt_d == '0);
    end
  end

  // live_q keeps rx_ready low while in reset.
  assign bus.rx_ready = live_q && !tx_valid_q && (state_q != EXEC);
  assign accept       = bus.rx_valid && bus.rx_ready;
  assign mark         = bus.rx_data[FRAME_MARK_BIT];
  assign is_exec      = (state_q == EXEC);

  // Parser next state; a marked byte always restarts the frame.
  always_comb begin
    state_d = state_q;
    if (is_exec) begin
      state_d = IDLE;
    end else if (accept) begin
      if (mark) begin
        state_d = GOT1;
      end else begin
        unique case (state_q)
          GOT1:    state_d = GOT2;
          GOT2:    state_d = EXEC;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Parser state and frame byte capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
      b0_q    <= '0;
      b1_q    <= '0;
      b2_q    <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (accept) begin
        if (mark) begin
          b0_q <= bus.rx_data[6:0];
        end else if (state_q == GOT1) begin
          b1_q <= bus.rx_data[6:0];
        end else if (state_q == GOT2) begin
          b2_q <= bus.rx_data[6:0];
        end
      end
    end
  end

  assign op         = b0_q[OP_MSB:OP_LSB];
  assign ch         = frame_ch(b0_q, b1_q);
  assign v          = frame_v(b1_q, b2_q);
  assign ch_ok      = 32'(ch) < OUTPUTS;
  assign v_ok       = 32'(v) < PERIOD;
  assign wr_off     = is_exec && (op == OP_SET_OFFSET) && ch_ok && v_ok;
  assign wr_duty    = is_exec && (op == OP_SET_DUTY) && ch_ok;
  assign commit_req = is_exec && (op == OP_COMMIT);

  // Reply selection for the frame being executed.
  always_comb begin
    reply_valid = 1'b0;
    reply_data  = 8'h00;
    if (is_exec) begin
      unique case (op)
        OP_SET_OFFSET: begin
          reply_valid = !(ch_ok && v_ok) || ACK_EN;
          reply_data  = (ch_ok && v_ok) ? {1'b1, b0_q} : REPLY_ERR;
        end
        OP_SET_DUTY: begin
          reply_valid = !ch_ok || ACK_EN;
          reply_data  = ch_ok ? {1'b1, b0_q} : REPLY_ERR;
        end
        OP_COMMIT: begin
          reply_valid = ACK_EN;
          reply_data  = {1'b1, b0_q};
        end
        default: begin
          reply_valid = 1'b1;
          reply_data  = QUERY_REPLY;
        end
      endcase
    end
  end

  // Reply holding register and commit request flag; a new COMMIT wins over the swap clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_valid_q     <= 1'b0;
      tx_data_q      <= 8'h00;
      commit_pending <= 1'b0;
    end else begin
      tx_valid_q     <= reply_valid || (tx_valid_q && !bus.tx_ready);
      commit_pending <= (commit_pending && !swap) || commit_req;
      if (reply_valid) begin
        tx_data_q <= reply_data;
      end
    end
  end

  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;

  // Shadow registers written by SET frames; read by the channels at swap time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < int'(OUTPUTS); j++) begin
        shadow_off[j]  <= '0;
        shadow_duty[j] <= DUTY_RESET;
      end
    end else begin
      for (int j = 0; j < int'(OUTPUTS); j++) begin
        if (wr_off && (ch == CH_WIDTH'(j))) begin
          shadow_off[j] <= OFFSET_WIDTH'(v);
        end
        if (wr_duty && (ch == CH_WIDTH'(j))) begin
          shadow_duty[j] <= OFFSET_WIDTH'(v);
        end
      end
    end
  end

  for (genvar j = 0; j < OUTPUTS; j++) begin : g_ch
    phase_channel #(
      .OFFSET_WIDTH(OFFSET_WIDTH),
      .PERIOD      (PERIOD)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .cnt        (cnt_q),
      .swap       (swap),
      .shadow_off (shadow_off[j]),
      .shadow_duty(shadow_duty[j]),
      .out        (out[j])
    );
  end

endmodule

// File: tb/tb_phased_array_ctrl.sv
// Directed plus randomized bench for phased_array_ctrl with a frame-level
// reference model of shadow/active values and a waveform predictor.
module tb_phased_array_ctrl;

  localparam int N = 88;
  localparam int P = 1250;
`ifdef PAC_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] out;
  logic         sync;
  logic         commit_pending;

  always #5 clk = ~clk;

  phased_array_ctrl_if bus ();

  phased_array_ctrl #(
    .OUTPUTS     (N),
    .OFFSET_WIDTH(12),
    .PERIOD      (P),
    .CH_WIDTH    (7)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .out           (out),
    .sync          (sync),
    .commit_pending(commit_pending)
  );

  // Number of clock edges since reset release; cnt equals k mod P.
  int unsigned k;
  always @(posedge clk or negedge rst) begin
    if (!rst) k <= 0;
    else      k <= k + 1;
  end

  int vectors = 0;
  int miscompares = 0;
  int m_soff[N], m_sduty[N], m_aoff[N], m_aduty[N];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < N; j++) begin
      m_soff[j] = 0; m_sduty[j] = P / 2; m_aoff[j] = 0; m_aduty[j] = P / 2;
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.rx_ready) check("rx_accept", {127'd0, bus.rx_ready}, 128'd1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic expect_reply(input bit has, input logic [7:0] val, input string tag);
    bit seen = 1'b0;
    logic [7:0] got = 8'h00;
    for (int t = 0; t < 6 && !seen; t++) begin
      @(negedge clk);
      if (bus.tx_valid) begin
        seen = 1'b1;
        got  = bus.tx_data;
      end
    end
    check({tag, "_valid"}, {127'd0, seen}, {127'd0, has});
    if (has && seen) check({tag, "_data"}, {120'd0, got}, {120'd0, val});
  endtask

  // Sends a complete frame; the model decides the reply and shadow effect.
  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input string tag);
    int op = int'(b0[6:5]);
    int ch = int'({b0[4:0], b1[6:5]});
    int v  = int'({b1[4:0], b2[6:0]});
    bit has;
    logic [7:0] val;
    case (op)
      0: if (ch < N && v < P) begin m_soff[ch] = v; has = ACK; val = b0; end
         else begin has = 1'b1; val = 8'hEE; end
      3: if (ch < N) begin m_sduty[ch] = v; has = ACK; val = b0; end
         else begin has = 1'b1; val = 8'hEE; end
      1: begin has = ACK; val = b0; end
      default: begin has = 1'b1; val = 8'(N); end
    endcase
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    expect_reply(has, val, tag);
  endtask

  task automatic set_val(input bit duty, input logic [6:0] ch, input logic [11:0] v,
                         input string tag);
    send_frame({1'b1, duty, duty, ch[6:2]}, {1'b0, ch[1:0], v[11:7]}, {1'b0, v[6:0]}, tag);
  endtask

  // Compares out and sync against the model for n cycles.
  task automatic check_period(input int n, input string tag);
    logic [N-1:0] e;
    int ph, d;
    for (int i = 0; i < n; i++) begin
      e = '0;
      if (k != 0) begin
        ph = int'((k - 1) % P);
        for (int j = 0; j < N; j++) begin
          d    = (ph + P - m_aoff[j]) % P;
          e[j] = (d < m_aduty[j]);
        end
      end
      check({tag, "_out"}, {40'd0, out}, {40'd0, e});
      check({tag, "_sync"}, {127'd0, sync}, {127'd0, (k != 0 && k % P == 0)});
      @(negedge clk);
    end
  endtask

  task automatic commit_and_check(input string tag);
    int t = 0;
    while (k % P != 100) @(negedge clk);
    send_frame(8'hA0, 8'h00, 8'h00, {tag, "_commit"});
    check({tag, "_pending_set"}, {127'd0, commit_pending}, 128'd1);
    while (commit_pending && t < P + 20) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_pending_clr"}, {127'd0, commit_pending}, 128'd0);
    check({tag, "_commit_phase"}, 128'(k % P), 128'd0);
    for (int j = 0; j < N; j++) begin
      m_aoff[j]  = m_soff[j];
      m_aduty[j] = m_sduty[j];
    end
    @(negedge clk);
    check_period(P, tag);
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_out", {40'd0, out}, 128'd0);
    check("rst_sync", {127'd0, sync}, 128'd0);
    check("rst_tx_valid", {127'd0, bus.tx_valid}, 128'd0);
    check("rst_tx_data", {120'd0, bus.tx_data}, 128'd0);
    check("rst_rx_ready", {127'd0, bus.rx_ready}, 128'd0);
    check("rst_pending", {127'd0, commit_pending}, 128'd0);
    rst = 1'b1;

    // Query after reset and default in-phase 50% waveform.
    send_frame(8'hC0, 8'h00, 8'h00, "query0");
    check_period(P, "default");

    // Out-of-range channel and offset.
    set_val(1'b0, 7'd100, 12'd10, "err_ch");
    set_val(1'b0, 7'd5, 12'd1300, "err_v");
    set_val(1'b1, 7'd120, 12'd7, "err_duty_ch");

    // Half-period shift on channel 5.
    set_val(1'b0, 7'd5, 12'd625, "off5");
    commit_and_check("shift5");

    // Dropped partial frame followed by a query, then a stray byte in IDLE.
    send_byte(8'h80);
    send_byte(8'h20);
    send_frame(8'hC0, 8'h00, 8'h00, "restart_query");
    send_byte(8'h12);
    expect_reply(1'b0, 8'h00, "stray");

    // Duty extremes on channel 0.
    set_val(1'b1, 7'd0, 12'd0, "duty0");
    commit_and_check("low0");
    set_val(1'b1, 7'd0, 12'd2000, "duty2000");
    commit_and_check("high0");

    // Back-pressure: a held reply blocks further input.
    bus.tx_ready = 1'b0;
    send_byte(8'hC0);
    send_byte(8'h00);
    send_byte(8'h00);
    for (int t = 0; t < 10 && !bus.tx_valid; t++) @(negedge clk);
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_rx_ready", {127'd0, bus.rx_ready}, 128'd0);
      check("bp_tx_valid", {127'd0, bus.tx_valid}, 128'd1);
      check("bp_tx_data", {120'd0, bus.tx_data}, 128'(N));
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    @(negedge clk);
    check("bp_drain", {127'd0, bus.tx_valid}, 128'd0);
    set_val(1'b0, 7'd3, 12'd100, "ack_set");

    // Randomized SET streams, each checked for shadow isolation then committed.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) begin
        if ($urandom_range(0, 1) == 0) begin
          set_val(1'b0, 7'($urandom_range(0, 110)), 12'($urandom_range(0, 1300)), "rnd_off");
        end else if ($urandom_range(0, 3) == 0) begin
          set_val(1'b1, 7'($urandom_range(0, 110)), 12'd4095, "rnd_duty_max");
        end else begin
          set_val(1'b1, 7'($urandom_range(0, 110)), 12'($urandom_range(0, 1300)), "rnd_duty");
        end
      end
      check_period(50, "rnd_shadow");
      commit_and_check("rnd_commit");
    end

    // Reset with a commit pending discards everything.
    while (k % P != 200) @(negedge clk);
    set_val(1'b0, 7'd7, 12'd300, "pre_rst_set");
    send_frame(8'hA0, 8'h00, 8'h00, "pre_rst_commit");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_pending", {127'd0, commit_pending}, 128'd0);
    check("midrst_out", {40'd0, out}, 128'd0);
    check("midrst_tx_valid", {127'd0, bus.tx_valid}, 128'd0);
    rst = 1'b1;
    model_reset();
    check_period(P + 2, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
